// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Width encoding matches the control unit's mem_width field.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } lsu_state_t;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    // Encoding 2'b11 behaves as a word access.
    function automatic logic is_word(input logic [1:0] width);
        return (width == MEM_W) || (width == 2'b11);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment: store data replication, write strobes and misalignment
// detection on the issue side; lane extraction and extension on the load side.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_addr_lo_i,
    input  logic [1:0]  st_width_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        misaligned_o,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [1:0]  ld_width_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] load_ext_o
);

    logic [31:0] shifted;

    always_comb begin
        wdata_o      = store_data_i;
        wstrb_o      = 4'b1111;
        misaligned_o = 1'b0;
        if (st_width_i == MEM_B) begin
            wdata_o = {4{store_data_i[7:0]}};
            wstrb_o = 4'b0001 << st_addr_lo_i;
        end else if (st_width_i == MEM_H) begin
            wdata_o      = {2{store_data_i[15:0]}};
            wstrb_o      = 4'b0011 << st_addr_lo_i;
            misaligned_o = st_addr_lo_i[0];
        end else if (is_word(st_width_i)) begin
            misaligned_o = |st_addr_lo_i;
        end
    end

    // Move the addressed lane down to bit 0 before extending.
    always_comb begin
        shifted    = rdata_i >> {ld_addr_lo_i, 3'b000};
        load_ext_o = rdata_i;
        if (ld_width_i == MEM_B) begin
            load_ext_o = {{24{~ld_unsigned_i & shifted[7]}}, shifted[7:0]};
        end else if (ld_width_i == MEM_H) begin
            load_ext_o = {{16{~ld_unsigned_i & shifted[15]}}, shifted[15:0]};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: captures an access, runs one bus request/response
// transaction with a response timeout, and stalls the pipeline meanwhile.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_width,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_err,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_we,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata,
    output logic [1:0]  dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // Handshakes: a request moves on the cycle req_valid && req_ready are both
    // high; rsp_valid is a single-cycle strobe honoured only in WAIT_RSP.

    lsu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      req_addr_q, req_wdata_q, load_data_q;
    logic [3:0]       req_wstrb_q;
    logic             req_we_q;
    logic [1:0]       width_q, addr_lo_q;
    logic             uns_q;

    logic [31:0] al_wdata, al_load;
    logic [3:0]  al_wstrb;
    logic        al_mis;
    logic        access, start, capture, latch_rsp, timeout;

    lsu_align u_align (
        .st_addr_lo_i (addr[1:0]),
        .st_width_i   (mem_width),
        .store_data_i (store_data),
        .wdata_o      (al_wdata),
        .wstrb_o      (al_wstrb),
        .misaligned_o (al_mis),
        .ld_addr_lo_i (addr_lo_q),
        .ld_width_i   (width_q),
        .ld_unsigned_i(uns_q),
        .rdata_i      (rsp_rdata),
        .load_ext_o   (al_load)
    );

    assign access = (mem_read | mem_write) & ~flush;
    assign start  = access & ~al_mis;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        latch_rsp = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (req_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response in the final counted cycle still wins over the error.
                if (rsp_valid) begin
                    latch_rsp = 1'b1;
                    state_d   = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            req_we_q    <= 1'b0;
            width_q     <= '0;
            addr_lo_q   <= '0;
            uns_q       <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                req_addr_q  <= {addr[31:2], 2'b00};
                req_wdata_q <= al_wdata;
                req_wstrb_q <= mem_write ? al_wstrb : 4'b0000;
                req_we_q    <= mem_write;
                width_q     <= mem_width;
                addr_lo_q   <= addr[1:0];
                uns_q       <= mem_unsigned;
            end
            if (latch_rsp) begin
                load_data_q <= req_we_q ? 32'd0 : al_load;
            end else if (timeout) begin
                load_data_q <= 32'd0;
            end
        end
    end

    // Combinational outputs are masked during reset so an aborted
    // transaction disappears from the bus in the reset cycle itself.
    assign stall      = ~rst & ((state_q == IDLE) ? start
                                : (state_q == REQ) || (state_q == WAIT_RSP));
    assign misaligned = ~rst & (state_q == IDLE) & access & al_mis;
    assign bus_err    = ~rst & timeout;
    assign req_valid  = ~rst & (state_q == REQ);
    assign req_we     = req_we_q;
    assign req_addr   = req_addr_q;
    assign req_wdata  = req_wdata_q;
    assign req_wstrb  = req_wstrb_q;
    assign load_data  = load_data_q;
    assign dbg_state  = state_q;

endmodule
